// File: rtl/tdl_tdc_pkg.sv
// Shared constants for the TDL TDC word path: channel state codes, word types,
// the data-word identifier and the transition-to-word-type decode.
package tdl_tdc_pkg;

    localparam int IDLE             = 0;
    localparam int TRIGGERED        = 1;
    localparam int RIS_EDGE         = 2;
    localparam int FAL_EDGE         = 3;
    localparam int COUNTER_OVERFLOW = 4;
    localparam int MISSED           = 5;
    localparam int RESET            = 6;
    localparam int CALIB            = 7;
    localparam int CALIB_HIT        = 8;

    typedef enum logic [2:0] {
        WT_TRIGGERED        = 3'd0,
        WT_RISING           = 3'd1,
        WT_FALLING          = 3'd2,
        WT_TIMESTAMP        = 3'd3,
        WT_COUNTER_OVERFLOW = 3'd4,
        WT_CALIB            = 3'd5,
        WT_MISS             = 3'd6,
        WT_RESET            = 3'd7
    } word_type_e;

    localparam logic [3:0] DATA_IDENTIFIER = 4'b0100;
    localparam int         WORD_BITS       = 32;

    // Returns 1 when the (previous, current) state pair produces a word.
    function automatic logic decode_transition(
        input  int         prev,
        input  int         cur,
        input  logic       en_trig,
        input  logic       en_ts,
        output word_type_e wtype
    );
        logic hit;
        hit   = 1'b1;
        wtype = WT_TRIGGERED;
        if (prev == IDLE && cur == TRIGGERED) begin
            hit = en_trig;
        end else if (prev == TRIGGERED && cur == RIS_EDGE) begin
            wtype = WT_RISING;
        end else if (prev == RIS_EDGE && cur == FAL_EDGE) begin
            wtype = WT_FALLING;
        end else if (prev == FAL_EDGE && cur == IDLE) begin
            wtype = WT_TIMESTAMP;
            hit   = en_ts;
        end else if (prev == COUNTER_OVERFLOW && cur == IDLE) begin
            wtype = WT_COUNTER_OVERFLOW;
        end else if (prev == MISSED && cur == IDLE) begin
            wtype = WT_MISS;
        end else if (prev == RESET && cur == IDLE) begin
            wtype = WT_RESET;
        end else if (prev == CALIB && cur == CALIB_HIT) begin
            wtype = WT_CALIB;
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

endpackage

// File: rtl/tdl_word_fifo.sv
// Synchronous first-word-fall-through FIFO for one channel's data words.
// Pushes into a full FIFO are ignored; pops from an empty FIFO are ignored.
module tdl_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide what is readable.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tdl_word_broker_mc.sv
// Multi-channel TDL TDC word broker: per-channel transition decode, per-channel FIFO,
// round-robin merge onto one ready/valid stream. Optional macro: TDL_BROKER_LOST_CNT_EN.
module tdl_word_broker_mc
    import tdl_tdc_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int CH_BITS        = 2,
    parameter int STATE_BITS     = 4,
    parameter int COUNTER_BITS   = 10,
    parameter int FINE_TIME_BITS = 2,
    parameter int ENCODE_BITS    = 7,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [CHANNELS*STATE_BITS-1:0]      tdc_state,
    input  logic [CHANNELS*COUNTER_BITS-1:0]    corse_time,
    input  logic [CHANNELS*FINE_TIME_BITS-1:0]  fine_time,
    input  logic [CHANNELS*ENCODE_BITS-1:0]     tdl_time,
    input  logic [15:0]                         timestamp,
    input  logic [CHANNELS-1:0]                 channel_en,
    input  logic                                en_write_timestamp,
    input  logic                                en_write_trigger_distance,
    input  logic                                out_ready,
    output logic                                out_valid,
    output logic [31:0]                         out_word,
    output logic [CHANNELS-1:0]                 fifo_overflow,
    output logic [CHANNELS*8-1:0]               lost_cnt
);
    localparam int PL        = 25 - CH_BITS;
    localparam int TIME_BITS = COUNTER_BITS + FINE_TIME_BITS + ENCODE_BITS;
    localparam int CAL_BITS  = FINE_TIME_BITS + ENCODE_BITS;
    localparam int PTR_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    if (TIME_BITS > PL) begin : g_bad_time_width
        $error("time payload does not fit the word payload field");
    end
    if (PL < 16) begin : g_bad_payload_width
        $error("payload field narrower than the 16-bit timestamp");
    end
    if (CHANNELS < 1 || CHANNELS > 64 || (2 ** CH_BITS) < CHANNELS) begin : g_bad_channels
        $error("CHANNELS out of range or CH_BITS too narrow");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [WORD_BITS-1:0] fifo_data [CHANNELS];
    logic [WORD_BITS-1:0] gen_word  [CHANNELS];
    logic [CHANNELS-1:0]  gen_valid;
    logic [CHANNELS-1:0]  fifo_full;
    logic [CHANNELS-1:0]  fifo_empty;
    logic [CHANNELS-1:0]  fifo_pop;
    logic [CHANNELS-1:0]  drop;

    // Full is a registered flag, so a same-cycle pop never rescues an arriving word.
    assign drop = gen_valid & fifo_full;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [CH_BITS-1:0] CH_ID = CH_BITS'(i);

        logic [STATE_BITS-1:0] prev_state;
        logic [STATE_BITS-1:0] cur_state;
        word_type_e            wtype;
        logic                  hit;
        logic [PL-1:0]         payload;

        assign cur_state = tdc_state[i*STATE_BITS +: STATE_BITS];

        always_ff @(posedge CLK) begin
            if (RST) prev_state <= STATE_BITS'(IDLE);
            else     prev_state <= cur_state;
        end

        // NOTE: every always_comb output gets a default first so no path infers a latch.
        always_comb begin
            payload = '0;
            hit     = decode_transition(int'(prev_state), int'(cur_state),
                                        en_write_trigger_distance, en_write_timestamp, wtype);
            case (wtype)
                WT_TRIGGERED, WT_RISING, WT_FALLING:
                    payload[TIME_BITS-1:0] = {corse_time[i*COUNTER_BITS +: COUNTER_BITS],
                                              fine_time[i*FINE_TIME_BITS +: FINE_TIME_BITS],
                                              tdl_time[i*ENCODE_BITS +: ENCODE_BITS]};
                WT_TIMESTAMP:
                    payload[PL-1 -: 16] = timestamp;
                WT_CALIB:
                    payload[CAL_BITS-1:0] = {fine_time[i*FINE_TIME_BITS +: FINE_TIME_BITS],
                                             tdl_time[i*ENCODE_BITS +: ENCODE_BITS]};
                default: payload = '0;
            endcase
        end

        assign gen_valid[i] = channel_en[i] && hit;
        assign gen_word[i]  = {DATA_IDENTIFIER, CH_ID, wtype, payload};

        tdl_word_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (WORD_BITS)
        ) u_fifo (
            .CLK       (CLK),
            .RST       (RST),
            .push      (gen_valid[i] && !fifo_full[i]),
            .push_data (gen_word[i]),
            .pop       (fifo_pop[i]),
            .pop_data  (fifo_data[i]),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i])
        );

`ifdef TDL_BROKER_LOST_CNT_EN
        logic [7:0] lost;

        always_ff @(posedge CLK) begin
            if (RST)                          lost <= '0;
            else if (drop[i] && lost != 8'hFF) lost <= lost + 8'd1;
        end

        assign lost_cnt[i*8 +: 8] = lost;
`else
        assign lost_cnt[i*8 +: 8] = 8'h00;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) fifo_overflow <= '0;
        else     fifo_overflow <= fifo_overflow | drop;
    end

    logic [PTR_BITS-1:0] rr_ptr;
    logic [PTR_BITS-1:0] pick;
    logic [PTR_BITS-1:0] idx;
    logic                pick_valid;
    logic                load;
    int                  sum;

    assign load = !out_valid || out_ready;

    // First non-empty channel at or after the pointer, wrapping modulo CHANNELS.
    always_comb begin
        pick       = rr_ptr;
        pick_valid = 1'b0;
        idx        = '0;
        sum        = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            sum = int'(rr_ptr) + k;
            if (sum >= CHANNELS) sum = sum - CHANNELS;
            idx = PTR_BITS'(sum);
            if (!pick_valid && !fifo_empty[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

    always_comb begin
        fifo_pop = '0;
        if (load && pick_valid) fifo_pop[pick] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= pick_valid;
            if (pick_valid) begin
                out_word <= fifo_data[pick];
                rr_ptr   <= (int'(pick) == CHANNELS - 1) ? '0 : pick + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tdl_word_broker_mc.sv
// Scoreboard bench for tdl_word_broker_mc: a queue-based reference model predicts the
// output word stream, a monitor compares every accepted word; directed and random phases.
module tb_tdl_word_broker_mc;

    localparam int CHANNELS       = 4;
    localparam int CH_BITS        = 2;
    localparam int STATE_BITS     = 4;
    localparam int COUNTER_BITS   = 10;
    localparam int FINE_TIME_BITS = 2;
    localparam int ENCODE_BITS    = 7;
    localparam int FIFO_DEPTH     = 4;
    localparam int PL             = 25 - CH_BITS;

    localparam int S_IDLE = 0, S_TRIG = 1, S_RIS = 2, S_FAL = 3, S_COVF = 4;
    localparam int S_MISS = 5, S_RST = 6, S_CAL = 7, S_CALHIT = 8;

    logic                                CLK = 1'b0;
    logic                                RST = 1'b1;
    logic [CHANNELS*STATE_BITS-1:0]      tdc_state = '0;
    logic [CHANNELS*COUNTER_BITS-1:0]    corse_time = '0;
    logic [CHANNELS*FINE_TIME_BITS-1:0]  fine_time = '0;
    logic [CHANNELS*ENCODE_BITS-1:0]     tdl_time = '0;
    logic [15:0]                         timestamp = '0;
    logic [CHANNELS-1:0]                 channel_en = '1;
    logic                                en_write_timestamp = 1'b1;
    logic                                en_write_trigger_distance = 1'b1;
    logic                                out_ready = 1'b1;
    logic                                out_valid;
    logic [31:0]                         out_word;
    logic [CHANNELS-1:0]                 fifo_overflow;
    logic [CHANNELS*8-1:0]               lost_cnt;

    always #5 CLK = ~CLK;

    tdl_word_broker_mc #(
        .CHANNELS       (CHANNELS),
        .CH_BITS        (CH_BITS),
        .STATE_BITS     (STATE_BITS),
        .COUNTER_BITS   (COUNTER_BITS),
        .FINE_TIME_BITS (FINE_TIME_BITS),
        .ENCODE_BITS    (ENCODE_BITS),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .CLK                       (CLK),
        .RST                       (RST),
        .tdc_state                 (tdc_state),
        .corse_time                (corse_time),
        .fine_time                 (fine_time),
        .tdl_time                  (tdl_time),
        .timestamp                 (timestamp),
        .channel_en                (channel_en),
        .en_write_timestamp        (en_write_timestamp),
        .en_write_trigger_distance (en_write_trigger_distance),
        .out_ready                 (out_ready),
        .out_valid                 (out_valid),
        .out_word                  (out_word),
        .fifo_overflow             (fifo_overflow),
        .lost_cnt                  (lost_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_words  = 0;
    logic [15:0] last_ts = '0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: per-channel word queues, one output slot, round-robin pointer.
    logic [31:0]         mq [CHANNELS][$];
    logic [31:0]         exp_q [$];
    int                  m_prev [CHANNELS];
    int                  m_lost [CHANNELS];
    logic [CHANNELS-1:0] m_ovf;
    bit                  m_slot;
    int                  m_ptr;

    function automatic bit model_word(input int ch, input int prev, input int cur,
                                      input bit et, input bit ets, input int corse,
                                      input int fine, input int tdl, input int ts,
                                      output logic [31:0] w);
        int          t;
        logic [31:0] pl;
        logic [31:0] time_pl;
        time_pl = (32'(corse) << (FINE_TIME_BITS + ENCODE_BITS)) | (32'(fine) << ENCODE_BITS) | 32'(tdl);
        w = '0;
        if (prev == S_IDLE && cur == S_TRIG) begin
            if (!et) return 1'b0;
            t = 0; pl = time_pl;
        end else if (prev == S_TRIG && cur == S_RIS) begin
            t = 1; pl = time_pl;
        end else if (prev == S_RIS && cur == S_FAL) begin
            t = 2; pl = time_pl;
        end else if (prev == S_FAL && cur == S_IDLE) begin
            if (!ets) return 1'b0;
            t = 3; pl = 32'(ts) << (PL - 16);
        end else if (prev == S_COVF && cur == S_IDLE) begin
            t = 4; pl = 0;
        end else if (prev == S_MISS && cur == S_IDLE) begin
            t = 6; pl = 0;
        end else if (prev == S_RST && cur == S_IDLE) begin
            t = 7; pl = 0;
        end else if (prev == S_CAL && cur == S_CALHIT) begin
            t = 5; pl = (32'(fine) << ENCODE_BITS) | 32'(tdl);
        end else begin
            return 1'b0;
        end
        w = 32'h4000_0000 | (32'(ch) << (PL + 3)) | (32'(t) << PL) | pl;
        return 1'b1;
    endfunction

    bit          mdl_load;
    bit          mdl_full [CHANNELS];
    bit          mdl_found;
    int          mdl_j;
    int          mdl_cur;
    logic [31:0] mdl_w;

    always @(posedge CLK) begin
        if (RST) begin
            if (m_slot && !out_ready && exp_q.size() > 0) void'(exp_q.pop_back());
            for (int c = 0; c < CHANNELS; c++) begin
                mq[c].delete();
                m_prev[c] = S_IDLE;
                m_lost[c] = 0;
            end
            m_ovf  = '0;
            m_slot = 1'b0;
            m_ptr  = 0;
        end else begin
            mdl_load = !m_slot || out_ready;
            for (int c = 0; c < CHANNELS; c++) mdl_full[c] = (mq[c].size() >= FIFO_DEPTH);
            if (mdl_load) begin
                m_slot    = 1'b0;
                mdl_found = 1'b0;
                for (int k = 0; k < CHANNELS; k++) begin
                    mdl_j = (m_ptr + k) % CHANNELS;
                    if (!mdl_found && mq[mdl_j].size() > 0) begin
                        mdl_found = 1'b1;
                        exp_q.push_back(mq[mdl_j].pop_front());
                        m_slot = 1'b1;
                        m_ptr  = (mdl_j + 1) % CHANNELS;
                    end
                end
            end
            for (int c = 0; c < CHANNELS; c++) begin
                mdl_cur = int'(tdc_state[c*STATE_BITS +: STATE_BITS]);
                if (channel_en[c] &&
                    model_word(c, m_prev[c], mdl_cur, en_write_trigger_distance, en_write_timestamp,
                               int'(corse_time[c*COUNTER_BITS +: COUNTER_BITS]),
                               int'(fine_time[c*FINE_TIME_BITS +: FINE_TIME_BITS]),
                               int'(tdl_time[c*ENCODE_BITS +: ENCODE_BITS]),
                               int'(timestamp), mdl_w)) begin
                    if (mdl_full[c]) begin
                        m_ovf[c] = 1'b1;
                        if (m_lost[c] < 255) m_lost[c]++;
                    end else begin
                        mq[c].push_back(mdl_w);
                    end
                end
                m_prev[c] = mdl_cur;
            end
        end
    end

    // Monitor: every accepted word must be the next one the model predicted.
    always @(negedge CLK) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_words++;
            if (out_word[PL+2:PL] == 3'd3) last_ts = out_word[PL-1 -: 16];
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_word: got %0h expected none", out_word);
            end else begin
                check("word", out_word, exp_q.pop_front());
            end
        end
    end

    function automatic int exp_lost(input int c);
`ifdef TDL_BROKER_LOST_CNT_EN
        return m_lost[c];
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_state(input int ch, input int st);
        tdc_state[ch*STATE_BITS +: STATE_BITS] = STATE_BITS'(st);
    endtask

    task automatic set_all(input int st);
        for (int c = 0; c < CHANNELS; c++) set_state(c, st);
    endtask

    task automatic drain(input string name);
        int left;
        int budget;
        out_ready = 1'b1;
        budget    = 0;
        left      = 1;
        while (left != 0 && budget < 200) begin
            tick();
            budget++;
            left = exp_q.size() + (m_slot ? 1 : 0);
            for (int c = 0; c < CHANNELS; c++) left += mq[c].size();
        end
        tick();
        check(name, left, 0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic check_flags(input string name);
        check({name, "_ovf"}, fifo_overflow, m_ovf);
        for (int c = 0; c < CHANNELS; c++) check({name, "_lost"}, lost_cnt[c*8 +: 8], exp_lost(c));
    endtask

    int base;
    logic [31:0] held;
    int nxt [9] = '{S_TRIG, S_RIS, S_FAL, S_IDLE, S_IDLE, S_IDLE, S_IDLE, S_CALHIT, S_IDLE};

    initial begin
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_word", out_word, 0);
        check("rst_ovf", fifo_overflow, 0);
        check("rst_lost", lost_cnt, 0);
        RST = 1'b0;

        // Channel 2 full hit sequence with both optional words enabled.
        corse_time[2*COUNTER_BITS +: COUNTER_BITS]   = 10'h155;
        fine_time[2*FINE_TIME_BITS +: FINE_TIME_BITS] = 2'd2;
        tdl_time[2*ENCODE_BITS +: ENCODE_BITS]        = 7'h2A;
        timestamp = 16'hBEEF;
        base = n_words;
        set_state(2, S_TRIG);
        tick();
        check("lat_edge1_valid", out_valid, 0);
        set_state(2, S_RIS);
        tick();
        check("lat_edge2_valid", out_valid, 1);
        check("lat_edge2_type", out_word[PL+2:PL], 0);
        check("lat_edge2_chan", out_word[PL+3 +: CH_BITS], 2);
        set_state(2, S_FAL);
        tick();
        set_state(2, S_IDLE);
        tick();
        drain("drain_seq1");
        check("seq1_count", n_words - base, 4);
        check("seq1_ts", last_ts, 16'hBEEF);

        // Same sequence with optional words disabled.
        en_write_timestamp = 1'b0;
        en_write_trigger_distance = 1'b0;
        base = n_words;
        set_state(2, S_TRIG); tick();
        set_state(2, S_RIS);  tick();
        set_state(2, S_FAL);  tick();
        set_state(2, S_IDLE); tick();
        drain("drain_seq2");
        check("seq2_count", n_words - base, 2);
        en_write_timestamp = 1'b1;
        en_write_trigger_distance = 1'b1;

        // Simultaneous triggers on all channels from pointer 0.
        do_reset();
        set_all(S_TRIG);
        tick();
        set_all(S_IDLE);
        for (int c = 0; c < CHANNELS; c++) begin
            tick();
            check("rr_valid", out_valid, 1);
            check("rr_chan", out_word[PL+3 +: CH_BITS], c);
        end
        drain("drain_rr");

        // Stall: six words on channel 1 against a blocked output.
        out_ready = 1'b0;
        base = n_words;
        set_state(1, S_TRIG); tick();
        set_state(1, S_RIS);  tick();
        set_state(1, S_FAL);  tick();
        set_state(1, S_IDLE); tick();
        set_state(1, S_TRIG); tick();
        set_state(1, S_RIS);  tick();
        set_state(1, S_IDLE); tick();
        held = out_word;
        check("stall_type", held[PL+2:PL], 0);
        for (int k = 0; k < 13; k++) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_hold", out_word, held);
        end
        check("stall_ovf", fifo_overflow, 4'b0010);
`ifdef TDL_BROKER_LOST_CNT_EN
        check("stall_lost", lost_cnt[15:8], 1);
`else
        check("stall_lost", lost_cnt[15:8], 0);
`endif
        drain("drain_stall");
        check("stall_count", n_words - base, 5);

        // Disabled channel keeps tracking its state; re-enabling mid-pulse emits nothing.
        do_reset();
        base = n_words;
        channel_en = 4'b1110;
        set_state(0, S_TRIG); tick();
        set_state(0, S_RIS);  tick();
        channel_en = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("reen_valid", out_valid, 0);
        end
        set_state(0, S_IDLE); tick();
        tick();
        check("reen_count", n_words - base, 0);

        // Random traffic against the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                int cur;
                cur = int'(tdc_state[c*STATE_BITS +: STATE_BITS]);
                if ($urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 3) != 0 && cur <= S_CALHIT) set_state(c, nxt[cur]);
                    else set_state(c, int'($urandom_range(0, 15)));
                end
                corse_time[c*COUNTER_BITS +: COUNTER_BITS]   = COUNTER_BITS'($urandom);
                fine_time[c*FINE_TIME_BITS +: FINE_TIME_BITS] = FINE_TIME_BITS'($urandom);
                tdl_time[c*ENCODE_BITS +: ENCODE_BITS]        = ENCODE_BITS'($urandom);
            end
            timestamp  = 16'($urandom);
            out_ready  = ($urandom_range(0, 9) < 6);
            channel_en = ($urandom_range(0, 7) == 0) ? CHANNELS'($urandom) : '1;
            en_write_timestamp        = ($urandom_range(0, 4) != 0);
            en_write_trigger_distance = ($urandom_range(0, 4) != 0);
            tick();
            if (cyc % 150 == 149) check_flags("rand");
        end
        set_all(S_IDLE);
        drain("drain_rand");
        check_flags("rand_end");

        // Reset with three words in flight discards all of them.
        do_reset();
        en_write_timestamp = 1'b0;
        out_ready = 1'b0;
        base = n_words;
        set_state(3, S_TRIG); tick();
        set_state(3, S_RIS);  tick();
        set_state(3, S_FAL);  tick();
        tick();
        check("pre_rst_valid", out_valid, 1);
        set_state(3, S_IDLE);
        RST = 1'b1;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ovf", fifo_overflow, 0);
        check("mid_rst_lost", lost_cnt, 0);
        RST = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        check("mid_rst_count", n_words - base, 0);
        check("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tdl_word_broker_mc.md
Name: tdl_word_broker_mc

Overview:
- Multi-channel successor of the single-channel TDL TDC word broker.
- Watches CHANNELS independent TDC state machines and turns each qualifying state transition into a 32-bit data word tagged with its channel number.
- Buffers words in one small FIFO per channel and merges them round-robin onto a single ready/valid stream toward the readout FIFO.
- Sits between the per-channel tdl_tdc cores and the shared data-out FIFO.

Parameters:
- CHANNELS, 4, number of TDC channels (1..64).
- CH_BITS, 2, width of the channel-ID field in the word; must satisfy 2^CH_BITS >= CHANNELS.
- STATE_BITS, 4, width of each channel's tdc_state.
- COUNTER_BITS, 10, coarse-time width.
- FINE_TIME_BITS, 2, fine-time width.
- ENCODE_BITS, 7, TDL-encoded time width.
- FIFO_DEPTH, 4, words per channel FIFO; power of 2, at least 2.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- tdc_state  in  CHANNELS*STATE_BITS  per-channel state; channel i occupies slice i.
- corse_time  in  CHANNELS*COUNTER_BITS  per-channel coarse time.
- fine_time  in  CHANNELS*FINE_TIME_BITS  per-channel fine time.
- tdl_time  in  CHANNELS*ENCODE_BITS  per-channel TDL time.
- timestamp  in  16  shared timestamp.
- channel_en  in  CHANNELS  per-channel word-generation enable.
- en_write_timestamp  in  1  enables TIMESTAMP words.
- en_write_trigger_distance  in  1  enables TRIGGERED words.
- out_ready  in  1  downstream accept.
- out_valid  out  1  word valid.
- out_word  out  32  data word.
- fifo_overflow  out  CHANNELS  sticky: word dropped on channel i.
- lost_cnt  out  CHANNELS*8  per-channel lost-word counters; all zero when the feature is disabled.

Behaviour:
- Reset values: out_valid 0, out_word 0, fifo_overflow 0, lost_cnt 0. All FIFOs are emptied, every prev_state is set to IDLE, and the round-robin pointer is set to 0. A reset mid-operation discards all buffered words and any word held on the output.
- Per-channel prev_state is registered every cycle, whether or not the channel is enabled.
- A word is generated when channel_en[i]=1 and {prev_state, tdc_state} matches one of these rows (previous -> current, word type, payload):
  - IDLE -> TRIGGERED: type TRIGGERED(0), time payload; generated only if en_write_trigger_distance=1.
  - TRIGGERED -> RIS_EDGE: type RISING(1), time payload.
  - RIS_EDGE -> FAL_EDGE: type FALLING(2), time payload.
  - FAL_EDGE -> IDLE: type TIMESTAMP(3), timestamp payload; generated only if en_write_timestamp=1.
  - COUNTER_OVERFLOW -> IDLE: type COUNTER_OVERFLOW(4), zero payload.
  - MISSED -> IDLE: type MISS(6), zero payload.
  - RESET -> IDLE: type RESET(7), zero payload.
  - CALIB -> CALIB_HIT: type CALIB(5), calibration payload.
  - Every other pair generates nothing.
- Word format: {4'b0100, channel[CH_BITS-1:0], type[2:0], payload[PL-1:0]} with PL = 25-CH_BITS.
  - Time payload: {corse, fine, tdl}, right-aligned and zero-padded.
  - Timestamp payload: the 16-bit timestamp in the payload MSBs, zero-filled below.
  - Calibration payload: {fine, tdl}, right-aligned.
  - Elaboration fails if COUNTER_BITS+FINE_TIME_BITS+ENCODE_BITS > PL or if PL < 16.
- FIFO write happens on the same edge the transition is seen (prev_state old, tdc_state new).
- FIFO full rule: fullness is judged at the start of the cycle. A word arriving at a full FIFO is dropped even if a pop occurs in the same cycle. A drop sets fifo_overflow[i] (cleared only by RST).
- Output register: loads when out_valid=0 or out_ready=1. Source is the first non-empty FIFO at or after the RR pointer; the pointer then moves to that channel+1, wrapping after CHANNELS-1.
- When out_valid=1 and out_ready=0, out_word and out_valid hold stable.
- Throughput: one word per cycle.
- Latency: the word appears on out_word 2 edges after tdc_state first shows the new state (empty FIFO, out_ready=1).
- Simultaneous transitions on all channels are all buffered; they emerge in RR order starting from the pointer.

Optional Feature:
- Macro: TDL_BROKER_LOST_CNT_EN.
- Defined: per-channel 8-bit saturating counter (stops at 255), incremented on each dropped word, exported on lost_cnt.
- Undefined: no counters are built, lost_cnt is tied to 0, and fifo_overflow is unchanged.

Decomposition:
- Package tdl_tdc_pkg holds:
  - State constants: IDLE=0, TRIGGERED=1, RIS_EDGE=2, FAL_EDGE=3, COUNTER_OVERFLOW=4, MISSED=5, RESET=6, CALIB=7, CALIB_HIT=8.
  - Word-type constants 0..7.
  - DATA_IDENTIFIER = 4'b0100.
- One sub-module, tdl_word_fifo: a synchronous FIFO (FIFO_DEPTH x 32) with full/empty flags, instantiated per channel.

Test Plan:
- Channel 2: IDLE->TRIGGERED->RIS_EDGE->FAL_EDGE->IDLE with corse=10'h155, fine=2, tdl=7'h2A, en_write_trigger_distance=1, en_write_timestamp=1, timestamp=16'hBEEF, out_ready=1 -> four words with channel field 2 and types 0, 1, 2, 3; the first appears 2 edges after TRIGGERED; the timestamp word payload MSBs equal BEEF.
- Same sequence with both enables at 0 -> only the RISING and FALLING words.
- All 4 channels IDLE->TRIGGERED on the same edge with pointer=0 -> words emerge from channels 0, 1, 2, 3 on consecutive cycles.
- out_ready=0 for 20 cycles while channel 1 produces 6 words (FIFO_DEPTH=4) -> output stalls with out_word stable. Of the 6 words, 1 is held in the output register, 4 fill the FIFO and 1 is dropped: fifo_overflow[1]=1, lost_cnt[1]=1 with the macro defined. After out_ready=1, 5 words drain in order.
- channel_en=4'b1110 with a transition on channel 0 -> no word. Re-enable while channel 0 remains in RIS_EDGE -> still no word, since prev_state has kept tracking the channel.
- Assert RST while 3 words are buffered -> next cycle out_valid=0, all flags and counters are 0, and no stale word ever appears.
